jzjpcc_branch_predictor: RTL and testbench

- Parametrised fetch-side predictor and decode-side resolution checker; successor to the decode-stage branch unit.
- Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Fetch gets a next-PC prediction in the same cycle.
- Decode feeds back the resolved outcome. The block trains the BTB and raises mispredict with the corrected PC, so fetch can flush instead of always stalling on control transfers.

---
 rtl/jzjpcc_bp_pkg.sv | 21 ++
 rtl/jzjpcc_btb_array.sv | 64 ++++++
 rtl/jzjpcc_branch_predictor.sv | 101 ++++++++++
 tb/tb_jzjpcc_branch_predictor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/jzjpcc_bp_pkg.sv
// Shared types and helpers for the jzjpcc fetch-side branch predictor.
package jzjpcc_bp_pkg;

   typedef enum logic [1:0] {
      CT_NONE   = 2'd0,
      CT_BRANCH = 2'd1,
      CT_JAL    = 2'd2,
      CT_JALR   = 2'd3
   } ct_type_t;

   localparam logic [1:0] STRONG_NT = 2'b00;
   localparam logic [1:0] WEAK_NT   = 2'b01;
   localparam logic [1:0] WEAK_T    = 2'b10;
   localparam logic [1:0] STRONG_T  = 2'b11;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      if (taken) return (cnt == STRONG_T)  ? STRONG_T  : cnt + 2'b01;
      else       return (cnt == STRONG_NT) ? STRONG_NT : cnt - 2'b01;
   endfunction

endpackage

// File: rtl/jzjpcc_btb_array.sv
// Direct-mapped BTB storage: two combinational read ports (fetch, decode) and
// one synchronous write port. Only the valid bits are reset.
module jzjpcc_btb_array
   import jzjpcc_bp_pkg::*;
#(
   parameter int PC_MAX_B    = 31,
   parameter int BTB_INDEX_B = 4,
   localparam int ENTRIES    = 2 ** BTB_INDEX_B,
   localparam int PC_W       = PC_MAX_B - 1,
   localparam int TAG_W      = PC_MAX_B - BTB_INDEX_B - 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [BTB_INDEX_B-1:0] i_fetch_idx,
   output logic                   o_fetch_valid,
   output logic [TAG_W-1:0]       o_fetch_tag,
   output logic [PC_W-1:0]        o_fetch_target,
   output ct_type_t               o_fetch_type,
   output logic [1:0]             o_fetch_counter,
   input  logic [BTB_INDEX_B-1:0] i_dec_idx,
   output logic                   o_dec_valid,
   output logic [TAG_W-1:0]       o_dec_tag,
   output logic [PC_W-1:0]        o_dec_target,
   output logic [1:0]             o_dec_counter,
   input  logic                   i_wr_en,
   input  logic [BTB_INDEX_B-1:0] i_wr_idx,
   input  logic                   i_wr_valid,
   input  logic [TAG_W-1:0]       i_wr_tag,
   input  logic [PC_W-1:0]        i_wr_target,
   input  ct_type_t               i_wr_type,
   input  logic [1:0]             i_wr_counter
);

   logic [ENTRIES-1:0]             r_valid;
   logic [ENTRIES-1:0][TAG_W-1:0]  r_tag;
   logic [ENTRIES-1:0][PC_W-1:0]   r_target;
   ct_type_t [ENTRIES-1:0]         r_type;
   logic [ENTRIES-1:0][1:0]        r_counter;

   assign o_fetch_valid   = r_valid[i_fetch_idx];
   assign o_fetch_tag     = r_tag[i_fetch_idx];
   assign o_fetch_target  = r_target[i_fetch_idx];
   assign o_fetch_type    = r_type[i_fetch_idx];
   assign o_fetch_counter = r_counter[i_fetch_idx];

   assign o_dec_valid     = r_valid[i_dec_idx];
   assign o_dec_tag       = r_tag[i_dec_idx];
   assign o_dec_target    = r_target[i_dec_idx];
   assign o_dec_counter   = r_counter[i_dec_idx];

   // Reset wins over a concurrent write so a flushed table stays empty.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid <= '0;
      end else if (i_wr_en) begin
         r_valid[i_wr_idx]   <= i_wr_valid;
         r_tag[i_wr_idx]     <= i_wr_tag;
         r_target[i_wr_idx]  <= i_wr_target;
         r_type[i_wr_idx]    <= i_wr_type;
         r_counter[i_wr_idx] <= i_wr_counter;
      end
   end

endmodule

// File: rtl/jzjpcc_branch_predictor.sv
// Fetch-side next-PC predictor backed by a BTB, trained and checked from decode.
module jzjpcc_branch_predictor
   import jzjpcc_bp_pkg::*;
#(
   parameter int         PC_MAX_B      = 31,
   parameter int         BTB_INDEX_B   = 4,
   parameter logic [1:0] COUNTER_ALLOC = 2'b10,
   localparam int        PC_W          = PC_MAX_B - 1,
   localparam int        TAG_W         = PC_MAX_B - BTB_INDEX_B - 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PC_MAX_B:2]   currentPC_fetch,
   output logic                predictTaken_fetch,
   output logic [PC_MAX_B:2]   predictedPC_fetch,
   input  logic                updateEnable_decode,
   input  ct_type_t            ctType_decode,
   input  logic [PC_MAX_B:2]   currentPC_decode,
   input  logic                actualTaken_decode,
   input  logic [PC_MAX_B:2]   actualTarget_decode,
   input  logic                predictedTaken_decode,
   input  logic [PC_MAX_B:2]   predictedPC_decode,
   output logic                mispredict,
   output logic [PC_MAX_B:2]   correctedPC
);

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   logic                   w_f_valid, w_d_valid;
   logic [TAG_W-1:0]       w_f_tag, w_d_tag;
   logic [PC_W-1:0]        w_f_target, w_d_target;
   ct_type_t               w_f_type;
   logic [1:0]             w_f_counter, w_d_counter;

   logic                   w_wr_en, w_wr_valid;
   logic [PC_W-1:0]        w_wr_target;
   logic [1:0]             w_wr_counter;

   logic                   w_f_hit, w_d_hit, w_act_taken;

   jzjpcc_btb_array #(.PC_MAX_B(PC_MAX_B), .BTB_INDEX_B(BTB_INDEX_B)) u_btb (
      .clock           (clock),
      .reset           (reset),
      .i_fetch_idx     (currentPC_fetch[BTB_INDEX_B+1:2]),
      .o_fetch_valid   (w_f_valid),
      .o_fetch_tag     (w_f_tag),
      .o_fetch_target  (w_f_target),
      .o_fetch_type    (w_f_type),
      .o_fetch_counter (w_f_counter),
      .i_dec_idx       (currentPC_decode[BTB_INDEX_B+1:2]),
      .o_dec_valid     (w_d_valid),
      .o_dec_tag       (w_d_tag),
      .o_dec_target    (w_d_target),
      .o_dec_counter   (w_d_counter),
      .i_wr_en         (w_wr_en),
      .i_wr_idx        (currentPC_decode[BTB_INDEX_B+1:2]),
      .i_wr_valid      (w_wr_valid),
      .i_wr_tag        (currentPC_decode[PC_MAX_B:BTB_INDEX_B+2]),
      .i_wr_target     (w_wr_target),
      .i_wr_type       (ctType_decode),
      .i_wr_counter    (w_wr_counter)
   );

   // Fetch lookup; jumps always redirect, branches follow the counter MSB.
   assign w_f_hit            = w_f_valid & (w_f_tag == currentPC_fetch[PC_MAX_B:BTB_INDEX_B+2]);
   assign predictTaken_fetch = w_f_hit & ((w_f_type != CT_BRANCH) | w_f_counter[1]);
   assign predictedPC_fetch  = predictTaken_fetch ? w_f_target : currentPC_fetch + PC_ONE;

   assign w_d_hit = w_d_valid & (w_d_tag == currentPC_decode[PC_MAX_B:BTB_INDEX_B+2]);

   always_comb begin
      w_wr_en      = 1'b0;
      w_wr_valid   = 1'b1;
      w_wr_target  = actualTarget_decode;
      w_wr_counter = COUNTER_ALLOC;
      case (ctType_decode)
         CT_BRANCH: begin
            if (w_d_hit) begin
               w_wr_en      = 1'b1;
               w_wr_counter = sat_update(w_d_counter, actualTaken_decode);
               w_wr_target  = actualTaken_decode ? actualTarget_decode : w_d_target;
            end else begin
               w_wr_en = actualTaken_decode;
            end
         end
         CT_JAL, CT_JALR: w_wr_en = 1'b1;
         default: begin
            w_wr_en    = w_d_hit;
            w_wr_valid = 1'b0;
         end
      endcase
      w_wr_en = w_wr_en & updateEnable_decode;
   end

   assign w_act_taken = actualTaken_decode & (ctType_decode != CT_NONE);
   assign mispredict  = updateEnable_decode &
                        ((predictedTaken_decode != w_act_taken) |
                         (w_act_taken & (predictedPC_decode != actualTarget_decode)));
   assign correctedPC = w_act_taken ? actualTarget_decode : currentPC_decode + PC_ONE;

endmodule

// File: tb/tb_jzjpcc_branch_predictor.sv
// Scoreboard bench: stimulus pushes expectations from a PC-keyed reference model.
module tb_jzjpcc_branch_predictor;
   import jzjpcc_bp_pkg::*;

   localparam int PW = 30;
   typedef logic [PW-1:0] pc_t;

   typedef struct {
      bit  ptk;
      pc_t ppc;
      bit  en;
      bit  mis;
      pc_t cpc;
   } exp_t;

   logic     clock = 1'b0;
   logic     reset = 1'b1;
   pc_t      currentPC_fetch = '0;
   logic     predictTaken_fetch;
   pc_t      predictedPC_fetch;
   logic     updateEnable_decode = 1'b0;
   ct_type_t ctType_decode = CT_NONE;
   pc_t      currentPC_decode = '0;
   logic     actualTaken_decode = 1'b0;
   pc_t      actualTarget_decode = '0;
   logic     predictedTaken_decode = 1'b0;
   pc_t      predictedPC_decode = '0;
   logic     mispredict;
   pc_t      correctedPC;

   jzjpcc_branch_predictor dut (
      .clock                 (clock),
      .reset                 (reset),
      .currentPC_fetch       (currentPC_fetch),
      .predictTaken_fetch    (predictTaken_fetch),
      .predictedPC_fetch     (predictedPC_fetch),
      .updateEnable_decode   (updateEnable_decode),
      .ctType_decode         (ctType_decode),
      .currentPC_decode      (currentPC_decode),
      .actualTaken_decode    (actualTaken_decode),
      .actualTarget_decode   (actualTarget_decode),
      .predictedTaken_decode (predictedTaken_decode),
      .predictedPC_decode    (predictedPC_decode),
      .mispredict            (mispredict),
      .correctedPC           (correctedPC)
   );

   always #5 clock = ~clock;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_push  = 0;
   int   n_pop   = 0;
   exp_t sb[$];

   // Reference model: one slot per index, owned by a whole PC.
   bit  m_v   [16];
   pc_t m_pc  [16];
   pc_t m_tgt [16];
   int  m_ty  [16];
   int  m_cnt [16];

   function automatic int slot(input pc_t pc);
      return int'(pc % 16);
   endfunction

   function automatic void mpred(input pc_t pc, output bit tk, output pc_t npc);
      int  s = slot(pc);
      bit  hit = m_v[s] && (m_pc[s] == pc);
      tk  = hit && (m_ty[s] != 1 || m_cnt[s] >= 2);
      npc = tk ? m_tgt[s] : PW'(pc + 1);
   endfunction

   function automatic void mtrain(input int ty, input pc_t pc, input bit tk, input pc_t tg);
      int s = slot(pc);
      bit hit = m_v[s] && (m_pc[s] == pc);
      case (ty)
         1: begin
            if (hit) begin
               m_cnt[s] = tk ? ((m_cnt[s] < 3) ? m_cnt[s] + 1 : 3)
                             : ((m_cnt[s] > 0) ? m_cnt[s] - 1 : 0);
               m_ty[s]  = 1;
               if (tk) m_tgt[s] = tg;
            end else if (tk) begin
               m_v[s] = 1; m_pc[s] = pc; m_tgt[s] = tg; m_ty[s] = 1; m_cnt[s] = 2;
            end
         end
         2, 3: begin
            m_v[s] = 1; m_pc[s] = pc; m_tgt[s] = tg; m_ty[s] = ty;
         end
         default: if (hit) m_v[s] = 0;
      endcase
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   always @(negedge clock) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_pop++;
         check("predictTaken_fetch", 32'(predictTaken_fetch), 32'(e.ptk));
         check("predictedPC_fetch", 32'(predictedPC_fetch), 32'(e.ppc));
         check("mispredict", 32'(mispredict), 32'(e.mis));
         if (e.en) check("correctedPC", 32'(correctedPC), 32'(e.cpc));
      end
   end

   task automatic cyc(input bit rst, input pc_t fpc, input bit en, input int ty, input pc_t dpc,
                      input bit tk, input pc_t tg, input bit pt, input pc_t pp);
      exp_t e;
      bit   act;
      @(posedge clock);
      #1;
      reset = rst; currentPC_fetch = fpc; updateEnable_decode = en;
      ctType_decode = ct_type_t'(ty[1:0]); currentPC_decode = dpc;
      actualTaken_decode = tk; actualTarget_decode = tg;
      predictedTaken_decode = pt; predictedPC_decode = pp;
      mpred(fpc, e.ptk, e.ppc);
      act   = (ty != 0) && tk;
      e.en  = en;
      e.mis = en && ((pt != act) || (act && pp != tg));
      e.cpc = act ? tg : PW'(dpc + 1);
      sb.push_back(e);
      n_push++;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_v[i] = 0;
      end else if (en) begin
         mtrain(ty, dpc, tk, tg);
      end
   endtask

   // Decode carries the prediction fetch would have made for its PC.
   task automatic dcyc(input pc_t fpc, input int ty, input pc_t dpc, input bit tk, input pc_t tg);
      bit  pt;
      pc_t pp;
      mpred(dpc, pt, pp);
      cyc(0, fpc, 1, ty, dpc, tk, tg, pt, pp);
   endtask

   task automatic fcyc(input pc_t fpc);
      cyc(0, fpc, 0, 0, '0, 0, '0, 0, '0);
   endtask

   function automatic pc_t rpc();
      return ($urandom % 10 == 0) ? '1 : PW'($urandom_range(0, 47));
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) begin
         m_v[i] = 0; m_pc[i] = '0; m_tgt[i] = '0; m_ty[i] = 0; m_cnt[i] = 0;
      end
      repeat (2) @(posedge clock);

      fcyc(PW'('h40));
      dcyc(PW'('h40), 1, PW'('h40), 1, PW'('h30));
      fcyc(PW'('h40));
      dcyc(PW'('h40), 1, PW'('h40), 0, PW'('h30));
      dcyc(PW'('h40), 1, PW'('h40), 0, PW'('h30));
      fcyc(PW'('h40));
      dcyc(PW'('h40), 1, PW'('h40), 0, PW'('h30));
      fcyc(PW'('h40));
      for (int i = 0; i < 5; i++) dcyc(PW'('h40), 1, PW'('h40), 1, PW'('h30));
      dcyc(PW'('h40), 1, PW'('h40), 0, PW'('h30));
      fcyc(PW'('h40));

      dcyc(PW'('h10), 3, PW'('h10), 1, PW'('h80));
      fcyc(PW'('h10));
      dcyc(PW'('h10), 3, PW'('h10), 1, PW'('h90));
      fcyc(PW'('h10));

      dcyc(PW'('h05), 2, PW'('h05), 1, PW'('h100));
      dcyc(PW'('h15), 2, PW'('h15), 1, PW'('h200));
      fcyc(PW'('h05));
      fcyc(PW'('h15));
      dcyc(PW'('h15), 0, PW'('h15), 0, PW'('h0));
      fcyc(PW'('h15));
      fcyc('1);

      cyc(1, PW'('h40), 1, 2, PW'('h20), 1, PW'('h300), 0, PW'('h21));
      fcyc(PW'('h40));
      fcyc(PW'('h20));
      fcyc(PW'('h10));

      for (int i = 0; i < 600; i++) begin
         pc_t fpc, dpc, tg, pp;
         int  ty;
         bit  tk, pt, en;
         fpc = rpc();
         dpc = rpc();
         ty  = int'((dpc >> 4) % 3) + 1;
         if ($urandom % 10 == 0) ty = 0;
         case (ty)
            1:       tk = ($urandom % 3) != 0;
            2, 3:    tk = 1;
            default: tk = $urandom % 2;
         endcase
         tg = (ty == 3) ? PW'('h80 + 16 * $urandom_range(0, 2)) : (dpc ^ PW'('h100));
         mpred(dpc, pt, pp);
         if ($urandom % 5 == 0) begin
            pt = $urandom % 2;
            pp = PW'($urandom_range(0, 'h120));
         end
         en = ($urandom % 5) != 0;
         cyc(i == 300, fpc, en, ty, dpc, tk, tg, pt, pp);
      end

      fcyc(PW'('h0));
      repeat (2) @(negedge clock);
      check("scoreboard_drain", 32'(n_pop), 32'(n_push));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
